// File: rtl/debounce_fsm.sv
// Two-flop synchroniser plus a four-state debouncer that accepts a level change only
// after it has stayed stable for STABLE_TICKS delay_tick pulses; also counts accepted presses.
module debounce_fsm #(
    parameter int STABLE_TICKS = 3,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sw,
    input  logic             delay_tick,
    input  logic             clr,
    output logic             db_level,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] press_count
);

    // state | meaning
    // ZERO  | debounced level 0, input agrees
    // WAIT1 | level 0, input high, counting stable ticks towards ONE
    // ONE   | debounced level 1, input agrees
    // WAIT0 | level 1, input low, counting stable ticks towards ZERO

    localparam int TW = $clog2(STABLE_TICKS + 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(STABLE_TICKS - 1);

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b11,
        WAIT0 = 2'b10
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] tick_cnt, cnt_next;
    logic          sw_s1, sw_s;
    logic          rise_next, fall_next, db_next;

    always_comb begin
        state_next = state;
        cnt_next   = tick_cnt;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
            ZERO: begin
                if (sw_s) begin
                    state_next = WAIT1;
                    cnt_next   = '0;
                end
            end
            WAIT1: begin
                // a reversal aborts the wait even when a tick arrives in the same cycle
                if (!sw_s) begin
                    state_next = ZERO;
                end else if (delay_tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        state_next = ONE;
                        cnt_next   = '0;
                        rise_next  = 1'b1;
                    end else begin
                        cnt_next = tick_cnt + 1'b1;
                    end
                end
            end
            ONE: begin
                if (!sw_s) begin
                    state_next = WAIT0;
                    cnt_next   = '0;
                end
            end
            WAIT0: begin
                if (sw_s) begin
                    state_next = ONE;
                end else if (delay_tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        state_next = ZERO;
                        cnt_next   = '0;
                        fall_next  = 1'b1;
                    end else begin
                        cnt_next = tick_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ZERO;
                cnt_next   = '0;
            end
        endcase
        db_next = (state_next == ONE) || (state_next == WAIT0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1       <= 1'b0;
            sw_s        <= 1'b0;
            state       <= ZERO;
            tick_cnt    <= '0;
            db_level    <= 1'b0;
            rise_tick   <= 1'b0;
            fall_tick   <= 1'b0;
            press_count <= '0;
        end else begin
            sw_s1     <= sw;
            sw_s      <= sw_s1;
            state     <= state_next;
            tick_cnt  <= cnt_next;
            db_level  <= db_next;
            rise_tick <= rise_next;
            fall_tick <= fall_next;
            if (clr) begin
                press_count <= '0;
            end else if (rise_next) begin
                press_count <= press_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_debounce_fsm.sv
// Directed bench for debounce_fsm: a level/pending-run model is checked every cycle,
// and scenario results are pinned with hand-computed literals.
module tb_debounce_fsm;
    localparam int ST = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset, sw, clr;
    logic          tick_auto, man_tick;
    logic          gen_tick = 1'b0;
    logic          delay_tick;
    logic          db_level, rise_tick, fall_tick;
    logic [CW-1:0] press_count;

    int errors = 0, checks = 0;
    int rise_seen = 0, fall_seen = 0;
    int tcnt = 0;
    bit mon_en = 1'b0;

    // model state
    logic [1:0] m_hist = 2'b00;
    logic       m_lvl = 1'b0, m_pend = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
    int         m_ticks = 0, m_cnt = 0;

    always #5 clk = ~clk;

    assign delay_tick = tick_auto ? gen_tick : man_tick;

    debounce_fsm #(.STABLE_TICKS(ST), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .sw(sw), .delay_tick(delay_tick), .clr(clr),
        .db_level(db_level), .rise_tick(rise_tick), .fall_tick(fall_tick),
        .press_count(press_count)
    );

    // one-cycle tick every 10 cycles
    always @(negedge clk) begin
        tcnt     = (tcnt == 9) ? 0 : tcnt + 1;
        gen_tick = (tcnt == 9);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: accepted level plus a pending run of the opposite input, measured in ticks.
    always @(posedge clk) begin
        logic sws;
        if (reset) begin
            m_hist = 2'b00; m_lvl = 0; m_pend = 0; m_ticks = 0;
            m_rise = 0; m_fall = 0; m_cnt = 0;
        end else begin
            sws    = m_hist[1];
            m_hist = {m_hist[0], sw};
            m_rise = 0;
            m_fall = 0;
            if (!m_pend) begin
                if (sws != m_lvl) begin
                    m_pend  = 1;
                    m_ticks = 0;
                end
            end else if (sws == m_lvl) begin
                m_pend = 0;
            end else if (delay_tick) begin
                m_ticks++;
                if (m_ticks == ST) begin
                    m_lvl  = sws;
                    m_pend = 0;
                    if (sws) begin
                        m_rise = 1;
                        m_cnt  = (m_cnt + 1) % (1 << CW);
                    end else begin
                        m_fall = 1;
                    end
                end
            end
            if (clr) m_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (rise_tick === 1'b1) rise_seen++;
        if (fall_tick === 1'b1) fall_seen++;
        if (mon_en) begin
            chk("cyc_db_level", int'(db_level), int'(m_lvl));
            chk("cyc_rise_tick", int'(rise_tick), int'(m_rise));
            chk("cyc_fall_tick", int'(fall_tick), int'(m_fall));
            chk("cyc_press_count", int'(press_count), m_cnt);
        end
    end

    task automatic step(input logic s, input logic t, input logic c);
        sw = s; man_tick = t; clr = c;
        @(negedge clk);
    endtask

    task automatic press_release();
        repeat (8) step(1'b1, 1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int r0, f0, n;
        reset = 1'b1; sw = 1'b0; clr = 1'b0; tick_auto = 1'b0; man_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_db_level", int'(db_level), 0);
        chk("reset_rise", int'(rise_tick), 0);
        chk("reset_fall", int'(fall_tick), 0);
        chk("reset_count", int'(press_count), 0);
        reset = 1'b0; mon_en = 1'b1; tick_auto = 1'b1;

        // bounce rejection
        r0 = rise_seen; f0 = fall_seen;
        for (int i = 0; i < 100; i++) begin
            sw = ((i / 7) % 2 == 0);
            @(negedge clk);
        end
        sw = 1'b0;
        repeat (40) @(negedge clk);
        chk("bounce_rise", rise_seen - r0, 0);
        chk("bounce_fall", fall_seen - f0, 0);
        chk("bounce_db", int'(db_level), 0);
        chk("bounce_count", int'(press_count), 0);

        // clean press
        r0 = rise_seen; f0 = fall_seen;
        sw = 1'b1; n = 0;
        while (db_level !== 1'b1 && n < 60) begin
            @(negedge clk); n++;
        end
        chk("press_latency_le44", int'(n <= 44), 1);
        repeat (5) @(negedge clk);
        chk("press_rise_once", rise_seen - r0, 1);
        chk("press_count1", int'(press_count), 1);
        chk("press_no_fall", fall_seen - f0, 0);

        // release aborted, then real release
        f0 = fall_seen;
        sw = 1'b0;
        repeat (18) @(negedge clk);
        sw = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_no_fall", fall_seen - f0, 0);
        chk("abort_db_high", int'(db_level), 1);
        sw = 1'b0; n = 0;
        while (db_level !== 1'b0 && n < 60) begin
            @(negedge clk); n++;
        end
        repeat (3) @(negedge clk);
        chk("release_fall_once", fall_seen - f0, 1);
        chk("release_db_low", int'(db_level), 0);

        // abort beats tick in WAIT1 with tick_cnt at its last value
        tick_auto = 1'b0;
        r0 = rise_seen;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        chk("prio_no_rise", int'(rise_tick), 0);
        chk("prio_db_low", int'(db_level), 0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        chk("prio_rise_total", rise_seen - r0, 0);

        // clr coinciding with the increment
        repeat (3) step(1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_rise_cycle", int'(rise_tick), 1);
        chk("clr_wins_count", int'(press_count), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("clr_count_after", int'(press_count), 0);
        repeat (8) step(1'b0, 1'b1, 1'b0);

        // wrap over 256 presses with delay_tick held high
        r0 = rise_seen;
        for (int p = 1; p <= 256; p++) begin
            press_release();
            if (p == 255) chk("wrap_at_255", int'(press_count), 255);
        end
        chk("wrap_to_zero", int'(press_count), 0);
        chk("wrap_rise_count", rise_seen - r0, 256);

        // reset while in WAIT0 with count 5
        repeat (4) press_release();
        repeat (8) step(1'b1, 1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        chk("pre_reset_count5", int'(press_count), 5);
        chk("pre_reset_db_high", int'(db_level), 1);
        reset = 1'b1;
        r0 = rise_seen; f0 = fall_seen;
        step(1'b1, 1'b0, 1'b0);
        chk("midrst_db", int'(db_level), 0);
        chk("midrst_count", int'(press_count), 0);
        chk("midrst_rise", int'(rise_tick), 0);
        chk("midrst_fall", int'(fall_tick), 0);
        reset = 1'b0; tick_auto = 1'b1;
        n = 0;
        while (db_level !== 1'b1 && n < 60) begin
            @(negedge clk); n++;
        end
        repeat (5) @(negedge clk);
        chk("requal_rise_once", rise_seen - r0, 1);
        chk("requal_fall_none", fall_seen - f0, 0);
        chk("requal_db", int'(db_level), 1);
        chk("requal_count", int'(press_count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
